// File: rtl/flag_event_collector_pkg.sv
// rtl/flag_event_collector_pkg.sv - shared defaults, level-width helper and control bundle for the flag event collector
package flag_event_collector_pkg;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_TS_W        = 16;
    localparam int DEF_DEPTH       = 4;
    localparam int DEF_DROP_W      = 8;

    // Occupancy needs one extra bit so that a full FIFO (level == DEPTH) is representable.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic push;
        logic pop;
        logic drop;
    } evt_ctl_t;

endpackage

// File: rtl/flag_event_collector_sync_fifo_fwft.sv
// rtl/flag_event_collector_sync_fifo_fwft.sv - first-word-fall-through FIFO with separately tracked level
module sync_fifo_fwft
    import flag_event_collector_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [W-1:0]              push_data,
    input  logic                      pop,
    output logic [W-1:0]              rd_data,
    output logic [lvl_w(DEPTH)-1:0]   level,
    output logic                      full,
    output logic                      empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = lvl_w(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/flag_event_collector.sv
// rtl/flag_event_collector.sv - synchronises flag, timestamps rising edges, buffers them and counts drops
module flag_event_collector
    import flag_event_collector_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int TS_W        = DEF_TS_W,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int DROP_W      = DEF_DROP_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TS_W-1:0]          out_ts,
    output logic [lvl_w(DEPTH)-1:0]  level,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_cnt,
    input  logic                     clr_ovf
);

    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    logic            s;
    logic            p;
    logic            evt;
    logic [TS_W-1:0] ts_cnt;
    logic            full;
    logic            empty;
    evt_ctl_t        ctl;

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign s = flag;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] chain;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    chain <= '0;
                end else begin
                    chain[0] <= flag;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        chain[i] <= chain[i-1];
                    end
                end
            end
            assign s = chain[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p      <= 1'b0;
            ts_cnt <= '0;
        end else begin
            p      <= s;
            ts_cnt <= ts_cnt + TS_W'(1);
        end
    end

    assign evt = s & ~p;

    // Full implies non-empty, so a raised out_ready always frees a slot for the incoming event.
    assign ctl.push = evt;
    assign ctl.pop  = out_ready;
    assign ctl.drop = evt & full & ~out_ready;

    sync_fifo_fwft #(
        .W     (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (ctl.push),
        .push_data (ts_cnt),
        .pop       (ctl.pop),
        .rd_data   (out_ts),
        .level     (level),
        .full      (full),
        .empty     (empty)
    );

    assign out_valid = ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (ctl.drop) begin
            overflow <= 1'b1;
            if (clr_ovf) begin
                drop_cnt <= DROP_W'(1);
            end else if (drop_cnt != DROP_MAX) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end else if (clr_ovf) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_flag_event_collector.sv
// tb/tb_flag_event_collector.sv - scoreboard bench for flag_event_collector
module tb_flag_event_collector;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flag = 1'b0;
    logic       out_ready = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       out_valid;
    logic [3:0] out_ts;
    logic [2:0] level;
    logic       overflow;
    logic [2:0] drop_cnt;

    int         edge_n;
    int         n_checks = 0;
    int         n_pass = 0;
    logic [3:0] exp_q[$];

    flag_event_collector #(
        .SYNC_STAGES (2),
        .TS_W        (4),
        .DEPTH       (4),
        .DROP_W      (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flag      (flag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ts    (out_ts),
        .level     (level),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    // edge_n = index of the next rising edge; edge 0 is the first edge after reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) edge_n <= 0;
        else     edge_n <= edge_n + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_edge(input int target, input int m);
        for (int i = 0; i < 64; i++) begin
            if (edge_n % m == target) break;
            nclk(1);
        end
        check("wait_edge", edge_n % m, target);
    endtask

    // One high clock, two low clocks; the event is pushed two edges after flag is sampled.
    task automatic pulse(input bit keep);
        flag = 1'b1;
        if (keep) exp_q.push_back(4'((edge_n + 2) % 16));
        nclk(1);
        flag = 1'b0;
        nclk(2);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0) break;
            nclk(1);
        end
        check("drain_done", exp_q.size(), 0);
        out_ready = 1'b0;
        check("drain_level", level, 0);
        check("drain_valid", out_valid, 0);
    endtask

    // Monitor: a handshake visible here completes at the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", out_ts, -1);
                end else begin
                    check("out_ts", out_ts, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_level", level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_out_ts", out_ts, 0);
        nclk(2);
        rst = 1'b0;

        // Level-high flag from edge 10 for 20 clocks: one event stamped 12.
        wait_edge(10, 1000);
        flag = 1'b1;
        exp_q.push_back(4'd12);
        wait_edge(12, 1000);
        check("t1_valid_before", out_valid, 0);
        nclk(1);
        check("t1_valid_after", out_valid, 1);
        check("t1_level", level, 1);
        check("t1_head_ts", out_ts, 12);
        out_ready = 1'b1;
        wait_edge(30, 1000);
        flag = 1'b0;
        nclk(3);
        check("t1_single_event", exp_q.size(), 0);
        check("t1_level_end", level, 0);
        out_ready = 1'b0;

        // Six pulses into a four-entry FIFO with no consumer.
        for (int i = 0; i < 6; i++) pulse(i < 4);
        nclk(1);
        check("t2_level", level, 4);
        check("t2_overflow", overflow, 1);
        check("t2_drop_cnt", drop_cnt, 2);
        drain();

        clr_ovf = 1'b1;
        nclk(1);
        clr_ovf = 1'b0;
        check("clr_overflow", overflow, 0);
        check("clr_drop_cnt", drop_cnt, 0);

        // Full FIFO, pop and push on the same edge.
        for (int i = 0; i < 4; i++) pulse(1'b1);
        nclk(1);
        check("t3_full", level, 4);
        flag = 1'b1;
        exp_q.push_back(4'((edge_n + 2) % 16));
        nclk(1);
        flag = 1'b0;
        nclk(1);
        out_ready = 1'b1;
        nclk(1);
        out_ready = 1'b0;
        check("t3_level", level, 4);
        check("t3_drop_cnt", drop_cnt, 0);
        check("t3_overflow", overflow, 0);
        drain();

        // Timestamp wrap: events stamped 15 then 1.
        wait_edge(13, 16);
        flag = 1'b1;
        exp_q.push_back(4'd15);
        nclk(1);
        flag = 1'b0;
        nclk(1);
        flag = 1'b1;
        exp_q.push_back(4'd1);
        nclk(1);
        flag = 1'b0;
        nclk(3);
        check("t4_level", level, 2);
        check("t4_head_ts", out_ts, 15);
        drain();

        // Saturation, then clear colliding with a drop.
        for (int i = 0; i < 13; i++) pulse(i < 4);
        nclk(1);
        check("t5_sat_drop_cnt", drop_cnt, 7);
        check("t5_sat_overflow", overflow, 1);
        flag = 1'b1;
        nclk(1);
        flag = 1'b0;
        nclk(1);
        clr_ovf = 1'b1;
        nclk(1);
        clr_ovf = 1'b0;
        check("t5_drop_wins_ovf", overflow, 1);
        check("t5_drop_wins_cnt", drop_cnt, 1);
        clr_ovf = 1'b1;
        nclk(1);
        clr_ovf = 1'b0;
        check("t5_clear_ovf", overflow, 0);
        check("t5_clear_cnt", drop_cnt, 0);
        drain();

        // Reset mid-stream with three queued events.
        for (int i = 0; i < 3; i++) pulse(1'b1);
        nclk(1);
        check("t6_level_pre", level, 3);
        #2;
        rst = 1'b1;
        #1;
        check("t6_valid_rst", out_valid, 0);
        check("t6_level_rst", level, 0);
        check("t6_ts_rst", out_ts, 0);
        exp_q.delete();
        flag = 1'b1;
        nclk(2);
        rst = 1'b0;
        exp_q.push_back(4'd2);
        nclk(10);
        check("t6_level_post", level, 1);
        check("t6_head_ts", out_ts, 2);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
